// File: rtl/stack_cpu_pkg.sv
// Shared encodings for the 8-bit stack machine: opcodes, ALU operations and
// the controller state enumeration used by both controller and datapath.
package stack_cpu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_PUSH = 3'b100;
    localparam logic [2:0] OP_POP  = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_JZ   = 3'b111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_AP1    = 4'd2,
        S_AP2    = 4'd3,
        S_AEX    = 4'd4,
        S_NP     = 4'd5,
        S_NEX    = 4'd6,
        S_PR     = 4'd7,
        S_PW     = 4'd8,
        S_POPW   = 4'd9,
        S_JMP    = 4'd10,
        S_JZ     = 4'd11
    } state_t;

    // Two-operand ALU instructions share the AP1/AP2/AEX path.
    function automatic logic is_binop(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
    endfunction

endpackage

// File: rtl/controller.sv
// Multicycle Moore controller for the stack-machine datapath. Outputs decode
// from state alone and are held at zero for as long as rst is low.
module controller
    import stack_cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       pcSrc,
    output logic       IorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       IRWrite,
    output logic       MtoS,
    output logic       ldA,
    output logic       ldB,
    output logic       srcA,
    output logic       srcB,
    output logic       push,
    output logic       pop,
    output logic       tos,
    output logic [1:0] ALUOp
);

    state_t state_r;
    state_t next_s;

    // State register; a low rst at the edge restarts at FETCH.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state and Moore output decode; reset masks every strobe.
    always_comb begin
        next_s      = S_FETCH;
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        pcSrc       = 1'b0;
        IorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        IRWrite     = 1'b0;
        MtoS        = 1'b0;
        ldA         = 1'b0;
        ldB         = 1'b0;
        srcA        = 1'b0;
        srcB        = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        tos         = 1'b0;
        ALUOp       = ALU_ADD;
        if (rst) begin
            case (state_r)
                S_FETCH: begin
                    memRead = 1'b1;
                    IRWrite = 1'b1;
                    srcB    = 1'b1;
                    pcWrite = 1'b1;
                    next_s  = S_DECODE;
                end
                S_DECODE: begin
                    tos = 1'b1;
                    ldA = 1'b1;
                    if (is_binop(opcode)) begin
                        next_s = S_AP1;
                    end else begin
                        case (opcode)
                            OP_NOT:  next_s = S_NP;
                            OP_PUSH: next_s = S_PR;
                            OP_POP:  next_s = S_POPW;
                            OP_JMP:  next_s = S_JMP;
                            OP_JZ:   next_s = S_JZ;
                            default: next_s = S_FETCH;
                        endcase
                    end
                end
                S_AP1: begin
                    pop    = 1'b1;
                    next_s = S_AP2;
                end
                S_AP2: begin
                    tos    = 1'b1;
                    ldB    = 1'b1;
                    pop    = 1'b1;
                    next_s = S_AEX;
                end
                // IR is stable through the instruction, so opcode[1:0] selects add/sub/and.
                S_AEX: begin
                    srcA  = 1'b1;
                    ALUOp = opcode[1:0];
                    push  = 1'b1;
                end
                S_NP: begin
                    pop    = 1'b1;
                    next_s = S_NEX;
                end
                S_NEX: begin
                    srcA  = 1'b1;
                    ALUOp = ALU_NOT;
                    push  = 1'b1;
                end
                S_PR: begin
                    IorD    = 1'b1;
                    memRead = 1'b1;
                    next_s  = S_PW;
                end
                S_PW: begin
                    MtoS = 1'b1;
                    push = 1'b1;
                end
                S_POPW: begin
                    IorD     = 1'b1;
                    memWrite = 1'b1;
                    pop      = 1'b1;
                end
                S_JMP: begin
                    pcSrc   = 1'b1;
                    pcWrite = 1'b1;
                end
                S_JZ: begin
                    pcSrc       = 1'b1;
                    pcWriteCond = 1'b1;
                end
                default: begin
                    next_s = S_FETCH;
                end
            endcase
        end else begin
            next_s = S_FETCH;
        end
    end

endmodule

// File: tb/tb_controller.sv
// Scoreboard bench for controller: stimulus queues the hand-derived control
// vector for every cycle, a negedge monitor pops and compares.
module tb_controller;

    logic       clk;
    logic       rst;
    logic [2:0] opcode;
    logic       pcWrite, pcWriteCond, pcSrc, IorD, memRead, memWrite, IRWrite;
    logic       MtoS, ldA, ldB, srcA, srcB, push, pop, tos;
    logic [1:0] ALUOp;

    controller dut (
        .clk(clk), .rst(rst), .opcode(opcode),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .pcSrc(pcSrc),
        .IorD(IorD), .memRead(memRead), .memWrite(memWrite), .IRWrite(IRWrite),
        .MtoS(MtoS), .ldA(ldA), .ldB(ldB), .srcA(srcA), .srcB(srcB),
        .push(push), .pop(pop), .tos(tos), .ALUOp(ALUOp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit order: pcWrite pcWriteCond pcSrc IorD memRead memWrite IRWrite MtoS
    //            ldA ldB srcA srcB push pop tos ALUOp[1:0]
    localparam logic [16:0] V_ZERO   = 17'b0_0_0_0_0_0_0_0_0_0_0_0_0_0_0_00;
    localparam logic [16:0] V_FETCH  = 17'b1_0_0_0_1_0_1_0_0_0_0_1_0_0_0_00;
    localparam logic [16:0] V_DECODE = 17'b0_0_0_0_0_0_0_0_1_0_0_0_0_0_1_00;
    localparam logic [16:0] V_AP1    = 17'b0_0_0_0_0_0_0_0_0_0_0_0_0_1_0_00;
    localparam logic [16:0] V_AP2    = 17'b0_0_0_0_0_0_0_0_0_1_0_0_0_1_1_00;
    localparam logic [16:0] V_AADD   = 17'b0_0_0_0_0_0_0_0_0_0_1_0_1_0_0_00;
    localparam logic [16:0] V_ASUB   = 17'b0_0_0_0_0_0_0_0_0_0_1_0_1_0_0_01;
    localparam logic [16:0] V_AAND   = 17'b0_0_0_0_0_0_0_0_0_0_1_0_1_0_0_10;
    localparam logic [16:0] V_NP     = 17'b0_0_0_0_0_0_0_0_0_0_0_0_0_1_0_00;
    localparam logic [16:0] V_NEX    = 17'b0_0_0_0_0_0_0_0_0_0_1_0_1_0_0_11;
    localparam logic [16:0] V_PR     = 17'b0_0_0_1_1_0_0_0_0_0_0_0_0_0_0_00;
    localparam logic [16:0] V_PW     = 17'b0_0_0_0_0_0_0_1_0_0_0_0_1_0_0_00;
    localparam logic [16:0] V_POPW   = 17'b0_0_0_1_0_1_0_0_0_0_0_0_0_1_0_00;
    localparam logic [16:0] V_JMP    = 17'b1_0_1_0_0_0_0_0_0_0_0_0_0_0_0_00;
    localparam logic [16:0] V_JZ     = 17'b0_1_1_0_0_0_0_0_0_0_0_0_0_0_0_00;

    typedef struct {
        logic [16:0] v;
        string       n;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic mon_en = 1'b0;
    int   cyc = 0;

    logic [16:0] act;
    assign act = {pcWrite, pcWriteCond, pcSrc, IorD, memRead, memWrite, IRWrite, MtoS,
                  ldA, ldB, srcA, srcB, push, pop, tos, ALUOp};

    // Monitor: one expected vector is consumed per enabled cycle.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (mon_en) begin
            n_cmp = n_cmp + 1;
            if (q.size() == 0) begin
                n_bad = n_bad + 1;
                $display("FAIL cyc%0d underflow: got %b with no expected vector", cyc, act);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (act !== e.v) begin
                    n_bad = n_bad + 1;
                    $display("FAIL cyc%0d %s: got %b want %b", cyc, e.n, act, e.v);
                end
            end
        end
    end

    task automatic step(input logic [16:0] v, input string n);
        exp_t e;
        e.v = v;
        e.n = n;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [2:0] op);
        opcode = op;
        step(V_FETCH, "fetch");
        step(V_DECODE, "decode");
        case (op)
            3'b000: begin step(V_AP1, "add_ap1"); step(V_AP2, "add_ap2"); step(V_AADD, "add_aex"); end
            3'b001: begin step(V_AP1, "sub_ap1"); step(V_AP2, "sub_ap2"); step(V_ASUB, "sub_aex"); end
            3'b010: begin step(V_AP1, "and_ap1"); step(V_AP2, "and_ap2"); step(V_AAND, "and_aex"); end
            3'b011: begin step(V_NP, "not_np"); step(V_NEX, "not_nex"); end
            3'b100: begin step(V_PR, "push_pr"); step(V_PW, "push_pw"); end
            3'b101: step(V_POPW, "pop_popw");
            3'b110: step(V_JMP, "jmp");
            default: step(V_JZ, "jz");
        endcase
    endtask

    logic [2:0] prog [0:9];

    initial begin
        prog[0] = 3'b100; prog[1] = 3'b100; prog[2] = 3'b001; prog[3] = 3'b101;
        prog[4] = 3'b000; prog[5] = 3'b010; prog[6] = 3'b011; prog[7] = 3'b110;
        prog[8] = 3'b111; prog[9] = 3'b000;

        rst = 1'b0;
        opcode = 3'b000;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        step(V_ZERO, "reset_hold");
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_instr(prog[i]);
        end

        // Abandon an ADD in AEX: reset for two edges, then restart at FETCH.
        opcode = 3'b000;
        step(V_FETCH, "pre_fetch");
        step(V_DECODE, "pre_decode");
        step(V_AP1, "pre_ap1");
        step(V_AP2, "pre_ap2");
        rst = 1'b0;
        step(V_ZERO, "reset_aex1");
        step(V_ZERO, "reset_aex2");
        rst = 1'b1;
        opcode = 3'b011;
        step(V_FETCH, "post_reset_fetch");
        step(V_DECODE, "post_reset_decode");
        step(V_NP, "post_reset_np");
        step(V_NEX, "post_reset_nex");
        run_instr(3'b111);

        mon_en = 1'b0;
        if (q.size() != 0) begin
            n_bad = n_bad + 1;
            $display("FAIL leftover: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
